// File: rtl/pc_state_reg_pkg.sv
// Shared Y86 definitions: status codes, icode constants and PC/status FSM encoding.
// Used by fetch, pc_update and the PC state register.
package pc_state_reg_pkg;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  localparam logic [3:0] ICODE_HALT = 4'h0;
  localparam logic [3:0] ICODE_JXX  = 4'h7;
  localparam logic [3:0] ICODE_CALL = 4'h8;
  localparam logic [3:0] ICODE_RET  = 4'h9;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

endpackage

// File: rtl/pc_state_reg_if.sv
// Fetch-side bundle between the PC state register and the rest of the pipeline.
interface pc_state_reg_if;
  logic [63:0] PC_new;
  logic [3:0]  icode;
  logic        instr_valid;
  logic        imem_error;
  logic        dmem_error;
  logic        stall;
  logic [63:0] PC;
  logic [2:0]  stat;
  logic        halted;
  logic [63:0] instr_count;

  modport master (
    output PC_new, icode, instr_valid, imem_error, dmem_error, stall,
    input  PC, stat, halted, instr_count
  );

  modport slave (
    input  PC_new, icode, instr_valid, imem_error, dmem_error, stall,
    output PC, stat, halted, instr_count
  );
endinterface

// File: rtl/pc_state_reg_stat_next.sv
// Fixed-priority fault classification for the instruction at PC.
module stat_next
  import pc_state_reg_pkg::*;
(
  input  logic       imem_error,
  input  logic       instr_valid,
  input  logic       dmem_error,
  input  logic [3:0] icode,
  output stat_t      stat_nxt,
  output logic       fault,
  output logic       halt
);

  always_comb begin
    stat_nxt = STAT_AOK;
    fault    = 1'b0;
    halt     = 1'b0;
    if (imem_error) begin
      stat_nxt = STAT_ADR;
      fault    = 1'b1;
    end else if (!instr_valid) begin
      stat_nxt = STAT_INS;
      fault    = 1'b1;
    end else if (dmem_error) begin
      stat_nxt = STAT_ADR;
      fault    = 1'b1;
    end else if (icode == ICODE_HALT) begin
      stat_nxt = STAT_HLT;
      halt     = 1'b1;
    end
  end

endmodule

// File: rtl/pc_state_reg.sv
// Program counter, status register and retired-instruction counter with a
// RUN/HALT/ERR sequencer; HALT and ERR are left only through rst.
module pc_state_reg
  import pc_state_reg_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic           clk,
  input  logic           rst,
  pc_state_reg_if.slave  bus
);

  state_t      state_q, state_d;
  stat_t       stat_q,  stat_d;
  logic [63:0] pc_q,    pc_d;
  logic [63:0] count_q, count_d;

  stat_t stat_nxt;
  logic  fault;
  logic  halt;

  stat_next u_stat_next (
    .imem_error  (bus.imem_error),
    .instr_valid (bus.instr_valid),
    .dmem_error  (bus.dmem_error),
    .icode       (bus.icode),
    .stat_nxt    (stat_nxt),
    .fault       (fault),
    .halt        (halt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      stat_q  <= STAT_AOK;
      pc_q    <= RESET_PC;
      count_q <= 64'd0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    pc_d    = pc_q;
    count_d = count_q;
    case (state_q)
      ST_RUN: begin
        if (!bus.stall) begin
          if (fault) begin
            state_d = ST_ERR;
            stat_d  = stat_nxt;
          end else if (halt) begin
            // The halt instruction itself counts as retired.
            state_d = ST_HALT;
            stat_d  = stat_nxt;
            count_d = count_q + 64'd1;
          end else begin
            stat_d  = stat_nxt;
            pc_d    = bus.PC_new;
            count_d = count_q + 64'd1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.PC          = pc_q;
  assign bus.stat        = stat_q;
  assign bus.halted      = (state_q != ST_RUN);
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_pc_state_reg.sv
// Directed bench for pc_state_reg with hand-computed expectations.
module tb_pc_state_reg;

  localparam logic [63:0] RPC = 64'h0000_0000_0000_0100;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  pc_state_reg_if bus ();

  pc_state_reg #(.RESET_PC(RPC)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [63:0] pc, input logic [2:0] st,
                           input logic hl, input logic [63:0] cnt);
    check({tag, ".pc"},     bus.PC,          pc);
    check({tag, ".stat"},   {61'd0, bus.stat}, {61'd0, st});
    check({tag, ".halted"}, {63'd0, bus.halted}, {63'd0, hl});
    check({tag, ".count"},  bus.instr_count, cnt);
  endtask

  task automatic idle_inputs();
    bus.PC_new      = 64'h0;
    bus.icode       = 4'h3;
    bus.instr_valid = 1'b1;
    bus.imem_error  = 1'b0;
    bus.dmem_error  = 1'b0;
    bus.stall       = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    check_all("reset", RPC, 3'd1, 1'b0, 64'd0);
    rst = 1'b0;

    // Three plain retirements of PC_new = 0x0A
    bus.PC_new = 64'h0A;
    tick();
    check_all("load1", 64'h0A, 3'd1, 1'b0, 64'd1);
    tick();
    tick();
    check_all("load3", 64'h0A, 3'd1, 1'b0, 64'd3);

    // Stall holds everything
    bus.PC_new = 64'h20;
    bus.stall  = 1'b1;
    tick();
    tick();
    check_all("stall", 64'h0A, 3'd1, 1'b0, 64'd3);
    bus.stall = 1'b0;
    tick();
    check_all("unstall", 64'h20, 3'd1, 1'b0, 64'd4);

    // Odd, unaligned value is loaded raw
    bus.PC_new = 64'hFFFF_0000_1234_5677;
    tick();
    check("raw_pc", bus.PC, 64'hFFFF_0000_1234_5677);

    bus.PC_new = 64'h14;
    tick();
    check_all("pc14", 64'h14, 3'd1, 1'b0, 64'd6);

    // Halt at 0x14, then HALT is terminal
    bus.icode  = 4'h0;
    bus.PC_new = 64'h40;
    tick();
    check_all("halt", 64'h14, 3'd2, 1'b1, 64'd7);
    for (int i = 0; i < 5; i++) begin
      bus.PC_new     = 64'h100 + 64'(i);
      bus.icode      = 4'(i + 1);
      bus.stall      = i[0];
      bus.imem_error = i[1];
      tick();
      check_all("halt_frozen", 64'h14, 3'd2, 1'b1, 64'd7);
    end
    idle_inputs();

    // imem_error beats invalid instruction
    do_reset();
    check_all("rst_from_halt", RPC, 3'd1, 1'b0, 64'd0);
    bus.imem_error  = 1'b1;
    bus.instr_valid = 1'b0;
    bus.PC_new      = 64'h50;
    tick();
    check_all("adr_wins", RPC, 3'd3, 1'b1, 64'd0);
    idle_inputs();
    bus.PC_new = 64'h58;
    tick();
    check_all("err_frozen", RPC, 3'd3, 1'b1, 64'd0);

    // Reset out of ERR, then normal loading resumes
    do_reset();
    check_all("rst_from_err", RPC, 3'd1, 1'b0, 64'd0);
    bus.PC_new = 64'h60;
    tick();
    check_all("resume", 64'h60, 3'd1, 1'b0, 64'd1);

    // Invalid instruction alone
    do_reset();
    bus.instr_valid = 1'b0;
    tick();
    check_all("ins", RPC, 3'd4, 1'b1, 64'd0);
    idle_inputs();

    // Invalid beats dmem_error
    do_reset();
    bus.instr_valid = 1'b0;
    bus.dmem_error  = 1'b1;
    tick();
    check("ins_over_dmem", {61'd0, bus.stat}, 64'd4);
    idle_inputs();

    // dmem_error beats halt
    do_reset();
    bus.dmem_error = 1'b1;
    bus.icode      = 4'h0;
    tick();
    check_all("dmem_over_halt", RPC, 3'd3, 1'b1, 64'd0);
    idle_inputs();

    // Reset wins over stall and faults mid-operation
    do_reset();
    bus.PC_new = 64'h70;
    tick();
    rst            = 1'b1;
    bus.stall      = 1'b1;
    bus.imem_error = 1'b1;
    bus.PC_new     = 64'h77;
    tick();
    check_all("rst_override", RPC, 3'd1, 1'b0, 64'd0);
    rst = 1'b0;
    idle_inputs();

    // Counter wrap
    force u_dut.count_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release u_dut.count_q;
    #1;
    check("preload", bus.instr_count, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.PC_new = 64'h88;
    tick();
    check_all("wrap", 64'h88, 3'd1, 1'b0, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_state_reg.md
PC_STATE_REG -- requirements
Module: pc_state_reg

Interface
REQ-001 Parameter: RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: PC_new  input  64  next PC from the PC-update stage.
REQ-005 Port: icode  input  4  decoded icode of the instruction at PC (0 = halt).
REQ-006 Port: instr_valid  input  1  high when icode/ifun at PC decodes to a legal instruction.
REQ-007 Port: imem_error  input  1  instruction-memory address error for the fetch at PC.
REQ-008 Port: dmem_error  input  1  data-memory address error for the current instruction.
REQ-009 Port: stall  input  1  high = hold all state this cycle (external wait).
REQ-010 Port: PC  output  64  registered program counter driving fetch.
REQ-011 Port: stat  output  3  registered status: AOK=1, HLT=2, ADR=3, INS=4.
REQ-012 Port: halted  output  1  high when the FSM is in HALT or ERR.
REQ-013 Port: instr_count  output  64  number of instructions retired since reset.

Function
REQ-014 The FSM SHALL have exactly three states: RUN, HALT, ERR.
REQ-015 In RUN with stall=1, PC, stat, state and instr_count SHALL hold their values.
REQ-016 In RUN with stall=0, the fault check SHALL use fixed priority: imem_error > !instr_valid > dmem_error > icode==0.
REQ-017 imem_error=1: next state ERR, stat<=ADR, PC held, count unchanged.
REQ-018 instr_valid=0 (no imem_error): next state ERR, stat<=INS, PC held, count unchanged.
REQ-019 dmem_error=1 (no higher fault): next state ERR, stat<=ADR, PC held, count unchanged.
REQ-020 icode==0 (no fault): next state HALT, stat<=HLT, PC held, instr_count incremented by 1.
REQ-021 No fault and icode!=0: PC<=PC_new, stat stays AOK, instr_count incremented by 1, state stays RUN.
REQ-022 HALT and ERR SHALL be terminal: PC, stat and instr_count frozen regardless of any input except rst.
REQ-023 stall SHALL have no effect in HALT or ERR.
REQ-024 Latency: a PC_new accepted at edge N SHALL appear on PC immediately after edge N (one cycle); there SHALL be no combinational path from any input to any output.
REQ-025 PC SHALL be loaded as a raw 64-bit value, with no alignment check or masking.
REQ-026 instr_count SHALL wrap from 64'hFFFF_FFFF_FFFF_FFFF to 0 without flagging.
REQ-027 halted SHALL be high exactly when state is HALT or ERR.

Reset
REQ-028 With rst=1 at a rising edge, the block SHALL go to PC=RESET_PC, stat=AOK, state=RUN, instr_count=0, halted=0.
REQ-029 rst SHALL override stall, all faults, and HALT/ERR; asserting it mid-operation SHALL discard the pending update.
REQ-030 Before the first reset edge, outputs are undefined; the bench SHALL apply rst for at least one cycle.

Structure
REQ-031 The following SHALL live in the shared Y86 package, reused by fetch and pc_update:
  - stat codes (AOK/HLT/ADR/INS)
  - icode constants (HALT=0, JXX=7, CALL=8, RET=9)
  - the FSM state encoding
REQ-032 The fault-priority logic SHALL be a single combinational sub-module, stat_next, with inputs (imem_error, instr_valid, dmem_error, icode) and outputs (next stat, fault flag, halt flag); everything else stays in pc_state_reg.

Verification
REQ-033 Reset then PC_new=64'h0A, icode=3, valid, 3 cycles -> PC=0x0A after the first edge, instr_count=3, stat=1.
REQ-034 stall=1 for 2 cycles with PC_new=0x20 -> PC and instr_count unchanged; after stall drops, PC=0x20 on the next edge.
REQ-035 icode=0 at PC=0x14 -> stat=2, halted=1, PC stays 0x14, count +1; then 5 cycles of varying PC_new -> no change.
REQ-036 imem_error=1 and instr_valid=0 together -> stat=3 (ADR wins), PC held; instr_valid=0 alone from a fresh reset -> stat=4.
REQ-037 In ERR, assert rst for one cycle -> PC=RESET_PC, stat=1, halted=0, instr_count=0; the next cycle resumes normal loads.
REQ-038 Preload instr_count to 2^64-1 by forcing, then retire one instruction -> instr_count=0, stat stays 1.
